dft_bin_accum: RTL and testbench
================================

Name: dft_bin_accum

Overview:
- Single-bin DFT engine for the spectrogram path; wraps the CORDIC sin/cos generator.
- Drives the CORDIC `theta` input with a per-sample phase k·n/N.
- Consumes the CORDIC `cosout`/`sinout` outputs, multiplies them by the time-aligned input sample, and accumulates X[k] = Σ x[n]·e^(−j2πkn/N) over one frame of N samples.
- Presents the complex result with a valid/ready handshake.

Parameters:
- N_LOG2, 10: frame length N = 2^N_LOG2 samples.
- IN_W, 16: input sample width, signed two's complement.
- CORDIC_LAT, 17: clock edges from `theta` capture to matching `cosout`/`sinout`.
- ACC_W, 48: accumulator/output width. Must satisfy ACC_W ≥ IN_W+18+N_LOG2.

Ports:
- CLK  in  1  system clock, rising edge.
- RST  in  1  reset, asynchronous, active-high.
- start  in  1  frame start request; honoured only in IDLE.
- bin_k  in  N_LOG2  bin index; latched on an accepted start.
- in_valid  in  1  input sample valid.
- in_ready  out  1  block accepts a sample this cycle.
- in_sample  in  IN_W  signed input sample.
- theta  out  20  phase to CORDIC; 0x00000 = 0 rad, 0x80000 = π rad.
- cos_in  in  18  CORDIC `cosout`, signed Q1.17.
- sin_in  in  18  CORDIC `sinout`, signed Q1.17.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts the result.
- out_re  out  ACC_W  signed real part.
- out_im  out  ACC_W  signed imaginary part.

Behaviour:
- Reset (async, RST=1): state=IDLE; in_ready=0; out_valid=0; out_re=out_im=0; theta=0; phase=0; count=0; accumulators=0; all delay-line valid tags=0.
- Reset mid-frame: abandons the frame; nothing is emitted after RST falls.
- States:
  - IDLE: in_ready=0. On start=1, latch bin_k, set inc = bin_k << (20−N_LOG2), phase=0, count=0, accumulators=0, then go to RUN.
  - RUN: in_ready=1. Accept = in_valid&in_ready. On each accept: push {1, in_sample} into the delay line, phase += inc (mod 2^20), count++. The accept that makes count reach N goes to DRAIN.
  - DRAIN: in_ready=0. Wait until every valid tag in the delay line, product stage and accumulate stage is 0, then go to DONE.
  - DONE: out_valid=1; out_re/out_im hold the accumulators stable. On out_ready=1, go to IDLE and drop out_valid on the next edge.
- start outside IDLE: ignored.
- in_valid outside RUN: ignored; the sample is not consumed.
- theta is combinationally the phase register, so the CORDIC captures the pre-increment phase on the same edge that accepts the sample.
- Delay line:
  - Depth CORDIC_LAT, entry 0 written on the accept edge.
  - Entry CORDIC_LAT−1 aligns with cos_in/sin_in.
  - Bubbles (in_valid gaps) propagate as tag=0 and do not affect the accumulators.
- Datapath:
  - Product stage (registered): pr = x·cos_in; pi = x·sin_in; full 34-bit signed.
  - Accumulate stage (registered): acc_re += sext(pr); acc_im −= sext(pi). Only when the tag is 1.
  - No saturation; wrap mod 2^ACC_W, unreachable under the parameter rule.
- Latency: out_valid rises CORDIC_LAT+2 edges after the edge accepting sample N−1, with continuous or gapped input.
- Throughput: one sample per clock in RUN.
- count width N_LOG2+1; phase wraps naturally at 2^20.
- bin_k=0 gives inc=0, so theta stays 0 for the whole frame (DC bin).

Test Plan:
- DC bin: N_LOG2=4, bin_k=0, 16 samples of +1000, in_valid always high → out_re ≈ 16·1000·131071 = 2,097,136,000 (±16·1000·16); out_im ≈ 0 (±16·1000·16); out_valid asserts exactly 19 edges after the 16th accept.
- Tone on-bin/off-bin: N_LOG2=6, input 1000·cos(2πn·3/64), bin_k=3 → |out_re| ≈ 32·1000·131071, out_im ≈ 0. Rerun with bin_k=5 → both results < 1% of the bin-3 magnitude.
- Gapped input: the DC test with in_valid toggling 1,0,0,1… → identical out_re/out_im. theta only advances on accepts: 0, inc, 2·inc….
- Back-pressure: hold out_ready=0 for 50 cycles in DONE → out_valid and outputs stable; start and in_valid pulses ignored; in_ready=0. Release out_ready → IDLE next edge, then a new start is accepted.
- Reset mid-frame: assert RST asynchronously after 7 accepts (between edges) → outputs clear immediately; no out_valid after release. A subsequent full frame yields a correct result.
- Phase wrap: N_LOG2=4, bin_k=15, inc=0xF0000 → theta sequence 0, 0xF0000, 0xE0000…; result matches the software DFT at bin 15 within tolerance.

Source files
------------

// File: rtl/dft_bin_accum_if.sv
// Bus bundle for the single-bin DFT engine: frame control, sample input,
// CORDIC phase/sin/cos exchange and the complex result handshake.
// The master side is whatever owns the sample stream and the CORDIC core;
// the slave side is the DFT engine itself.
interface dft_bin_accum_if #(
    parameter int N_LOG2 = 10,
    parameter int IN_W   = 16,
    parameter int ACC_W  = 48
);
    logic                     start;
    logic [N_LOG2-1:0]        bin_k;
    logic                     in_valid;
    logic                     in_ready;
    logic signed [IN_W-1:0]   in_sample;
    logic [19:0]              theta;
    logic signed [17:0]       cos_in;
    logic signed [17:0]       sin_in;
    logic                     out_valid;
    logic                     out_ready;
    logic signed [ACC_W-1:0]  out_re;
    logic signed [ACC_W-1:0]  out_im;

    modport master (
        output start, bin_k, in_valid, in_sample, cos_in, sin_in, out_ready,
        input  in_ready, theta, out_valid, out_re, out_im
    );

    modport slave (
        input  start, bin_k, in_valid, in_sample, cos_in, sin_in, out_ready,
        output in_ready, theta, out_valid, out_re, out_im
    );
endinterface

// File: rtl/dft_bin_accum.sv
// Single-bin DFT engine. Steps the CORDIC phase by k*2^20/N per accepted
// sample, carries each sample down a tagged delay line matching the CORDIC
// latency, multiplies it by the returned cos/sin and accumulates
// X[k] = sum x[n] * (cos - j sin) over one frame of N samples.
module dft_bin_accum #(
    parameter int N_LOG2     = 10,
    parameter int IN_W       = 16,
    parameter int CORDIC_LAT = 17,
    parameter int ACC_W      = 48
) (
    input logic              CLK,
    input logic              RST,
    dft_bin_accum_if.slave   bus
);
    localparam logic [N_LOG2:0] LAST_CNT = (N_LOG2+1)'((1 << N_LOG2) - 1);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t                   state;
    logic [19:0]              phase;
    logic [19:0]              inc;
    logic [N_LOG2:0]          count;
    logic                     in_ready_r;
    logic                     out_valid_r;
    logic                     accept;

    logic [CORDIC_LAT-1:0]    dl_v;
    logic signed [IN_W-1:0]   dl_x [CORDIC_LAT];

    logic                     prod_v;
    logic signed [IN_W+17:0]  prod_re;
    logic signed [IN_W+17:0]  prod_im;

    logic signed [ACC_W-1:0]  acc_re;
    logic signed [ACC_W-1:0]  acc_im;

    assign accept        = bus.in_valid & in_ready_r;
    assign bus.in_ready  = in_ready_r;
    assign bus.out_valid = out_valid_r;
    assign bus.theta     = phase;
    assign bus.out_re    = acc_re;
    assign bus.out_im    = acc_im;

    // Frame control: latch the phase step, count accepted samples, wait for
    // the pipeline to empty, then hold the result until it is taken.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state       <= IDLE;
            phase       <= '0;
            inc         <= '0;
            count       <= '0;
            in_ready_r  <= 1'b0;
            out_valid_r <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        inc        <= 20'(bus.bin_k) << (20 - N_LOG2);
                        phase      <= '0;
                        count      <= '0;
                        in_ready_r <= 1'b1;
                        state      <= RUN;
                    end
                end
                RUN: begin
                    if (accept) begin
                        phase <= phase + inc;
                        count <= count + 1'b1;
                        if (count == LAST_CNT) begin
                            in_ready_r <= 1'b0;
                            state      <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if ((dl_v == '0) && !prod_v) begin
                        out_valid_r <= 1'b1;
                        state       <= DONE;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        out_valid_r <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Valid tags ride alongside the samples so bubbles never reach the accumulators.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            dl_v <= '0;
        end else begin
            dl_v <= {dl_v[CORDIC_LAT-2:0], accept};
        end
    end

    // Sample data shifts every cycle; only the matching tag decides whether it counts.
    always_ff @(posedge CLK) begin
        dl_x[0] <= bus.in_sample;
        for (int i = 1; i < CORDIC_LAT; i++) begin
            dl_x[i] <= dl_x[i-1];
        end
    end

    // Product stage: the oldest delay-line entry lines up with this cycle's cos/sin.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            prod_v  <= 1'b0;
            prod_re <= '0;
            prod_im <= '0;
        end else begin
            prod_v  <= dl_v[CORDIC_LAT-1];
            prod_re <= dl_x[CORDIC_LAT-1] * bus.cos_in;
            prod_im <= dl_x[CORDIC_LAT-1] * bus.sin_in;
        end
    end

    // Accumulate stage: the imaginary part subtracts because the kernel is e^(-j*theta).
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            acc_re <= '0;
            acc_im <= '0;
        end else if ((state == IDLE) && bus.start) begin
            acc_re <= '0;
            acc_im <= '0;
        end else if (prod_v) begin
            acc_re <= acc_re + ACC_W'(prod_re);
            acc_im <= acc_im - ACC_W'(prod_im);
        end
    end
endmodule

// File: tb/tb_dft_bin_accum.sv
// Bench for the single-bin DFT engine with a behavioural CORDIC model.
// Frames of directed samples are driven with hand-computed expected results
// queued into a scoreboard; a monitor pops and compares on each handshake.
module tb_dft_bin_accum;
    localparam int N_LOG2     = 4;
    localparam int N          = 16;
    localparam int IN_W       = 16;
    localparam int CORDIC_LAT = 17;
    localparam int ACC_W      = 48;
    localparam real PI        = 3.14159265358979323846;

    // 16 * 1000 * 131071 and 8 * 1000 * 131071
    localparam longint DC_RE  = 64'sd2097136000;
    localparam longint TONE   = 64'sd1048568000;
    localparam longint TOL    = 64'sd2000000;

    typedef struct {
        string  name;
        longint re;
        longint im;
        longint tol;
    } exp_t;

    logic CLK = 1'b0;
    logic RST;

    dft_bin_accum_if #(.N_LOG2(N_LOG2), .IN_W(IN_W), .ACC_W(ACC_W)) bus ();

    dft_bin_accum #(
        .N_LOG2(N_LOG2), .IN_W(IN_W), .CORDIC_LAT(CORDIC_LAT), .ACC_W(ACC_W)
    ) dut (
        .CLK(CLK),
        .RST(RST),
        .bus(bus.slave)
    );

    exp_t   sb_q [$];
    exp_t   mon_e;
    int     n_checks = 0;
    int     n_fails  = 0;

    int sine16 [16] = '{0, 383, 707, 924, 1000, 924, 707, 383,
                        0, -383, -707, -924, -1000, -924, -707, -383};
    int dc_samp   [N];
    int tone3     [N];
    int tone1     [N];

    logic [19:0] theta_pipe [CORDIC_LAT] = '{default: '0};

    always #5 CLK = ~CLK;

    // Behavioural CORDIC: quantised Q1.17 cos/sin of the phase captured CORDIC_LAT edges ago.
    function automatic logic signed [17:0] trig_q(input logic [19:0] th, input bit want_cos);
        real a;
        real r;
        a = 2.0 * PI * $itor(th) / 1048576.0;
        r = want_cos ? $cos(a) : $sin(a);
        r = r * 131071.0;
        return 18'($rtoi(r >= 0.0 ? r + 0.5 : r - 0.5));
    endfunction

    always @(posedge CLK) begin
        theta_pipe[0] <= bus.theta;
        for (int i = 1; i < CORDIC_LAT; i++) theta_pipe[i] <= theta_pipe[i-1];
    end

    assign bus.cos_in = trig_q(theta_pipe[CORDIC_LAT-1], 1'b1);
    assign bus.sin_in = trig_q(theta_pipe[CORDIC_LAT-1], 1'b0);

    task automatic check_output(input string name, input longint act, input longint expv, input longint tol);
        n_checks++;
        if (act > expv + tol || act < expv - tol) begin
            n_fails++;
            $display("[TB] FAIL %s: got %0d, expected %0d (+/-%0d)", name, act, expv, tol);
        end
    endtask

    // Scoreboard monitor: a result is taken on the edge after valid&ready is seen here.
    always @(negedge CLK) begin
        if (!RST && bus.out_valid && bus.out_ready) begin
            if (sb_q.size() == 0) begin
                n_checks++;
                n_fails++;
                $display("[TB] FAIL unexpected_result: got out_valid=1, expected no result pending");
            end else begin
                mon_e = sb_q.pop_front();
                check_output({mon_e.name, "_re"}, longint'(bus.out_re), mon_e.re, mon_e.tol);
                check_output({mon_e.name, "_im"}, longint'(bus.out_im), mon_e.im, mon_e.tol);
            end
        end
    end

    task automatic apply_stimulus(input string name, input logic [N_LOG2-1:0] k, input int samp [N],
                                  input int gap, input longint exp_re, input longint exp_im,
                                  input longint tol, input bit hold_ready);
        logic [19:0] inc;
        logic [19:0] exp_theta;
        exp_t        e;
        int          cycles;
        inc    = 20'(k) << (20 - N_LOG2);
        e.name = name;
        e.re   = exp_re;
        e.im   = exp_im;
        e.tol  = tol;
        sb_q.push_back(e);
        bus.bin_k = k;
        bus.start = 1'b1;
        @(posedge CLK); #1;
        bus.start = 1'b0;
        exp_theta = '0;
        for (int n = 0; n < N; n++) begin
            if (n > 0) begin
                for (int g = 0; g < gap; g++) begin
                    bus.in_valid = 1'b0;
                    @(posedge CLK); #1;
                end
            end
            bus.in_valid  = 1'b1;
            bus.in_sample = 16'(samp[n]);
            check_output({name, "_theta"}, longint'(bus.theta), longint'(exp_theta), 0);
            @(posedge CLK); #1;
            exp_theta = exp_theta + inc;
        end
        bus.in_valid = 1'b0;
        cycles = 0;
        while (!bus.out_valid && cycles < 100) begin
            @(posedge CLK); #1;
            cycles++;
        end
        check_output({name, "_latency"}, longint'(cycles), longint'(CORDIC_LAT + 2), 0);
        if (!hold_ready) begin
            @(posedge CLK); #1;
        end
    endtask

    initial begin
        #300000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int bad;
        int vcount;
        for (int n = 0; n < N; n++) begin
            dc_samp[n] = 1000;
            tone3[n]   = sine16[(3 * n) % 16];
            tone1[n]   = sine16[n];
        end

        RST           = 1'b1;
        bus.start     = 1'b0;
        bus.bin_k     = '0;
        bus.in_valid  = 1'b0;
        bus.in_sample = '0;
        bus.out_ready = 1'b1;
        repeat (3) @(posedge CLK);
        #1;
        check_output("reset_in_ready", longint'(bus.in_ready), 0, 0);
        check_output("reset_out_valid", longint'(bus.out_valid), 0, 0);
        check_output("reset_theta", longint'(bus.theta), 0, 0);
        check_output("reset_out_re", longint'(bus.out_re), 0, 0);
        check_output("reset_out_im", longint'(bus.out_im), 0, 0);
        RST = 1'b0;
        @(posedge CLK); #1;

        apply_stimulus("dc", 4'd0, dc_samp, 0, DC_RE, 0, 0, 1'b0);
        apply_stimulus("tone_bin3", 4'd3, tone3, 0, 0, -TONE, TOL, 1'b0);
        apply_stimulus("tone_bin5", 4'd5, tone3, 0, 0, 0, TOL, 1'b0);
        apply_stimulus("dc_gapped", 4'd0, dc_samp, 2, DC_RE, 0, 0, 1'b0);
        apply_stimulus("wrap_bin15", 4'd15, tone1, 0, 0, TONE, TOL, 1'b0);

        bus.out_ready = 1'b0;
        apply_stimulus("backpressure", 4'd0, dc_samp, 0, DC_RE, 0, 0, 1'b1);
        bad = 0;
        for (int c = 0; c < 50; c++) begin
            bus.start    = (c % 2 == 0);
            bus.in_valid = (c % 3 == 0);
            @(posedge CLK); #1;
            if (!bus.out_valid || bus.in_ready || longint'(bus.out_re) != DC_RE || bus.out_im != 0)
                bad++;
        end
        check_output("bp_hold_bad_cycles", longint'(bad), 0, 0);
        bus.start     = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge CLK); #1;
        check_output("bp_release_out_valid", longint'(bus.out_valid), 0, 0);
        apply_stimulus("after_bp", 4'd0, dc_samp, 0, DC_RE, 0, 0, 1'b0);

        bus.bin_k = 4'd3;
        bus.start = 1'b1;
        @(posedge CLK); #1;
        bus.start = 1'b0;
        for (int n = 0; n < 7; n++) begin
            bus.in_valid  = 1'b1;
            bus.in_sample = 16'(tone3[n]);
            @(posedge CLK); #1;
        end
        #1;
        RST = 1'b1;
        #1;
        check_output("midrst_theta", longint'(bus.theta), 0, 0);
        check_output("midrst_in_ready", longint'(bus.in_ready), 0, 0);
        check_output("midrst_out_valid", longint'(bus.out_valid), 0, 0);
        bus.in_valid = 1'b0;
        @(posedge CLK); #1;
        RST = 1'b0;
        vcount = 0;
        for (int c = 0; c < 40; c++) begin
            @(posedge CLK); #1;
            if (bus.out_valid) vcount++;
        end
        check_output("midrst_no_output", longint'(vcount), 0, 0);
        apply_stimulus("after_reset", 4'd0, dc_samp, 0, DC_RE, 0, 0, 1'b0);

        repeat (3) @(posedge CLK);
        #1;
        check_output("scoreboard_drained", longint'(sb_q.size()), 0, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule
